// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

  // Forward-select value meaning "use register-file data"
  localparam int unsigned FWD_RF       = 0;
  localparam int unsigned ALU_LAT_DEF  = 1;
  localparam int unsigned LOAD_LAT_DEF = 2;

  // Entry field widths; addresses are zero-extended into ENTRY_AW bits
  localparam int unsigned ENTRY_AW = 8;
  localparam int unsigned LAT_W    = 4;

  typedef struct packed {
    logic                v;
    logic [ENTRY_AW-1:0] addr;
    logic [LAT_W-1:0]    lat;
  } entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard/forwarding response bundle.
interface hazard_scoreboard_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned SW = 2,
  parameter int unsigned CW = 32
);
  logic          hold;
  logic          flush;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wr_en;
  logic [AW-1:0] id_wr_addr;
  logic          id_is_load;
  logic          stall;
  logic [SW-1:0] ex_fwd_rs;
  logic [SW-1:0] ex_fwd_rt;
  logic [CW-1:0] stall_cnt;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr_en, id_wr_addr, id_is_load,
    input  stall, ex_fwd_rs, ex_fwd_rt, stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr_en, id_wr_addr, id_is_load,
    output stall, ex_fwd_rs, ex_fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_entry_shift.sv
// In-flight writer pipeline: entry 0 is EX, entry NSTAGE-1 is WB.
module sb_entry_shift
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  entry_t              inEntry,
  output entry_t [NSTAGE-1:0] entries
);

  // Advance one stage per unfrozen cycle; the WB entry falls off the end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else if (!hold) begin
      entries[0] <= inEntry;
      for (int i = 1; i < int'(NSTAGE); i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection, stall generation and EX forward selects for ID.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned SW       = 2,
  parameter int unsigned CW       = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  entry_t [NSTAGE-1:0] entries;
  entry_t              newEntry;

  logic             rsHit;
  logic             rtHit;
  logic [SW-1:0]    rsAge;
  logic [SW-1:0]    rtAge;
  logic [LAT_W-1:0] rsLat;
  logic [LAT_W-1:0] rtLat;
  logic             rsMatch;
  logic             rtMatch;
  logic             rsWait;
  logic             rtWait;
  logic             stallC;
  logic             bubble;
  logic [SW-1:0]    fwdRsNext;
  logic [SW-1:0]    fwdRtNext;

  sb_entry_shift #(.NSTAGE(NSTAGE)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.hold),
    .inEntry (newEntry),
    .entries (entries)
  );

  // Youngest in-flight writer of rs and rt; oldest-first scan so the youngest overwrites, WB skipped
  always_comb begin
    rsHit = 1'b0;
    rtHit = 1'b0;
    rsAge = '0;
    rtAge = '0;
    rsLat = '0;
    rtLat = '0;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      if ((i < int'(NSTAGE) - 1) && entries[i].v) begin
        if (entries[i].addr == ENTRY_AW'(bus.id_rs)) begin
          rsHit = 1'b1;
          rsAge = SW'(i + 1);
          rsLat = entries[i].lat;
        end
        if (entries[i].addr == ENTRY_AW'(bus.id_rt)) begin
          rtHit = 1'b1;
          rtAge = SW'(i + 1);
          rtLat = entries[i].lat;
        end
      end
    end
  end

  // Stall when a producer's result is not yet forwardable; flush wins and makes a bubble
  always_comb begin
    rsMatch   = bus.id_valid & bus.id_use_rs & (bus.id_rs != AW'(0)) & rsHit;
    rtMatch   = bus.id_valid & bus.id_use_rt & (bus.id_rt != AW'(0)) & rtHit;
    rsWait    = rsMatch & (int'(rsAge) < int'(rsLat));
    rtWait    = rtMatch & (int'(rtAge) < int'(rtLat));
    stallC    = bus.id_valid & ~bus.flush & (rsWait | rtWait);
    bubble    = stallC | bus.flush;
    fwdRsNext = (rsMatch & ~bubble) ? rsAge + SW'(1) : SW'(FWD_RF);
    fwdRtNext = (rtMatch & ~bubble) ? rtAge + SW'(1) : SW'(FWD_RF);

    newEntry.v    = bus.id_valid & bus.id_wr_en & (bus.id_wr_addr != AW'(0)) & ~bubble;
    newEntry.addr = ENTRY_AW'(bus.id_wr_addr);
    newEntry.lat  = bus.id_is_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
  end

  assign bus.stall = stallC;

  // Selects travel with the instruction into EX; stall counter saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_fwd_rs <= SW'(FWD_RF);
      bus.ex_fwd_rt <= SW'(FWD_RF);
      bus.stall_cnt <= '0;
    end else if (!bus.hold) begin
      bus.ex_fwd_rs <= fwdRsNext;
      bus.ex_fwd_rt <= fwdRtNext;
      if (stallC && (bus.stall_cnt != '1)) begin
        bus.stall_cnt <= bus.stall_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two configurations (3 stages / load 2, 4 stages / load 3) on one stimulus stream.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       hold;
    logic       flush;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRs;
    logic       useRt;
    logic       wr;
    logic [4:0] wa;
    logic       ld;
  } stim_t;

  typedef struct {
    bit wr;
    int addr;
    bit ld;
  } slot_t;

  typedef struct {
    int     rsA;
    int     rtA;
    int     rsB;
    int     rtB;
    longint cntA;
    longint cntB;
  } fexp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(5), .SW(2), .CW(32)) busA ();
  hazard_scoreboard_if #(.AW(5), .SW(3), .CW(32)) busB ();

  hazard_scoreboard #(.NSTAGE(3), .AW(5), .ALU_LAT(1), .LOAD_LAT(2), .SW(2), .CW(32)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  hazard_scoreboard #(.NSTAGE(4), .AW(5), .ALU_LAT(1), .LOAD_LAT(3), .SW(3), .CW(32)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: issue history per configuration, newest first
  slot_t  hist [2][8];
  int     fwdRsM [2];
  int     fwdRtM [2];
  longint cntM [2];
  bit     lastStall [2];

  logic [1:0] stallQ [$];
  fexp_t      fwdQ [$];

  bit countOn = 1'b0;
  int obsA = 0;
  int obsB = 0;

  function automatic int nstOf(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic int loadLatOf(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic stim_t ins(input bit valid, input int rs, input int rt, input bit useRs,
                                input bit useRt, input bit wr, input int wa, input bit ld);
    stim_t s;
    s.hold  = 1'b0;
    s.flush = 1'b0;
    s.valid = valid;
    s.rs    = 5'(rs);
    s.rt    = 5'(rt);
    s.useRs = useRs;
    s.useRt = useRt;
    s.wr    = wr;
    s.wa    = 5'(wa);
    s.ld    = ld;
    return s;
  endfunction

  task automatic driveBus(input stim_t s);
    busA.hold = s.hold;       busB.hold = s.hold;
    busA.flush = s.flush;     busB.flush = s.flush;
    busA.id_valid = s.valid;  busB.id_valid = s.valid;
    busA.id_rs = s.rs;        busB.id_rs = s.rs;
    busA.id_rt = s.rt;        busB.id_rt = s.rt;
    busA.id_use_rs = s.useRs; busB.id_use_rs = s.useRs;
    busA.id_use_rt = s.useRt; busB.id_use_rt = s.useRt;
    busA.id_wr_en = s.wr;     busB.id_wr_en = s.wr;
    busA.id_wr_addr = s.wa;   busB.id_wr_addr = s.wa;
    busA.id_is_load = s.ld;   busB.id_is_load = s.ld;
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) hist[d][i] = '{wr: 1'b0, addr: 0, ld: 1'b0};
      fwdRsM[d] = 0;
      fwdRtM[d] = 0;
      cntM[d]   = 0;
    end
  endtask

  // Age of the most recent issued writer of src still short of WB (1 = previous issue)
  task automatic findProducer(input int d, input int src, output bit hit, output int age, output int lat);
    hit = 1'b0;
    age = 0;
    lat = 0;
    for (int a = 1; a < nstOf(d); a++) begin
      if (!hit && hist[d][a-1].wr && hist[d][a-1].addr == src) begin
        hit = 1'b1;
        age = a;
        lat = hist[d][a-1].ld ? loadLatOf(d) : 1;
      end
    end
  endtask

  task automatic modelStep(input int d, input stim_t s, output bit st);
    bit hs, ht;
    int as_, at, ls, lt;
    hs = 1'b0; ht = 1'b0; as_ = 0; at = 0; ls = 0; lt = 0;
    if (s.valid && s.useRs && s.rs != 0) findProducer(d, int'(s.rs), hs, as_, ls);
    if (s.valid && s.useRt && s.rt != 0) findProducer(d, int'(s.rt), ht, at, lt);
    st = s.valid && !s.flush && ((hs && as_ < ls) || (ht && at < lt));
    if (!s.hold) begin
      for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = '{wr: (s.valid && s.wr && s.wa != 0 && !st && !s.flush), addr: int'(s.wa), ld: s.ld};
      if (st || s.flush) begin
        fwdRsM[d] = 0;
        fwdRtM[d] = 0;
      end else begin
        fwdRsM[d] = hs ? as_ + 1 : 0;
        fwdRtM[d] = ht ? at + 1 : 0;
      end
      if (st && cntM[d] < 64'hFFFF_FFFF) cntM[d]++;
    end
  endtask

  // One ID cycle: drive at the falling edge and queue what both DUTs should show
  task automatic step(input stim_t s);
    bit stA, stB;
    fexp_t f;
    @(negedge clk);
    driveBus(s);
    modelStep(0, s, stA);
    modelStep(1, s, stB);
    lastStall[0] = stA;
    lastStall[1] = stB;
    stallQ.push_back({stB, stA});
    f.rsA = fwdRsM[0]; f.rtA = fwdRtM[0]; f.cntA = cntM[0];
    f.rsB = fwdRsM[1]; f.rtB = fwdRtM[1]; f.cntB = cntM[1];
    fwdQ.push_back(f);
  endtask

  // Keep the instruction in ID until neither configuration stalls it
  task automatic issue(input stim_t s);
    int n = 0;
    do begin
      step(s);
      n++;
    end while ((lastStall[0] || lastStall[1]) && n < 8);
  endtask

  // Monitor: stall is checked mid-cycle, selects and counter just after the edge
  initial begin
    logic [1:0] e;
    fexp_t f;
    forever begin
      @(negedge clk);
      #3;
      if (stallQ.size() > 0) begin
        e = stallQ.pop_front();
        chk("stallA", longint'(busA.stall), longint'(e[0]));
        chk("stallB", longint'(busB.stall), longint'(e[1]));
        if (countOn) begin
          obsA += int'(busA.stall);
          obsB += int'(busB.stall);
        end
      end
      @(posedge clk);
      #1;
      if (fwdQ.size() > 0) begin
        f = fwdQ.pop_front();
        chk("fwdRsA", longint'(busA.ex_fwd_rs), longint'(f.rsA));
        chk("fwdRtA", longint'(busA.ex_fwd_rt), longint'(f.rtA));
        chk("cntA",   longint'(busA.stall_cnt), f.cntA);
        chk("fwdRsB", longint'(busB.ex_fwd_rs), longint'(f.rsB));
        chk("fwdRtB", longint'(busB.ex_fwd_rt), longint'(f.rtB));
        chk("cntB",   longint'(busB.stall_cnt), f.cntB);
      end
    end
  end

  task automatic checkCleared(input string tag);
    chk({tag, "_stallA"}, longint'(busA.stall), 0);
    chk({tag, "_rsA"},    longint'(busA.ex_fwd_rs), 0);
    chk({tag, "_rtA"},    longint'(busA.ex_fwd_rt), 0);
    chk({tag, "_cntA"},   longint'(busA.stall_cnt), 0);
    chk({tag, "_stallB"}, longint'(busB.stall), 0);
    chk({tag, "_rsB"},    longint'(busB.ex_fwd_rs), 0);
    chk({tag, "_cntB"},   longint'(busB.stall_cnt), 0);
  endtask

  initial begin
    stim_t s;
    stim_t idle;
    idle = ins(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    driveBus(idle);
    resetModel();
    #3;
    checkCleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // ALU back-to-back: add $3<-$1,$2 ; sub $4<-$3,$5
    issue(ins(1, 1, 2, 1, 1, 1, 3, 0));
    issue(ins(1, 3, 5, 1, 1, 1, 4, 0));
    step(idle);

    // Load-use: lw $3 ; add $4<-$3,$3
    issue(ins(1, 1, 0, 1, 0, 1, 3, 1));
    countOn = 1'b1;
    issue(ins(1, 3, 3, 1, 1, 1, 4, 0));
    #4;
    countOn = 1'b0;
    chk("loadUseLenA", longint'(obsA), 1);
    chk("loadUseLenB", longint'(obsB), 2);
    step(idle);
    step(idle);

    // Youngest wins: addi $3 ; addi $3 ; or $6<-$3,$0
    issue(ins(1, 1, 0, 1, 0, 1, 3, 0));
    issue(ins(1, 2, 0, 1, 0, 1, 3, 0));
    issue(ins(1, 3, 0, 1, 1, 1, 6, 0));
    step(idle);

    // Register zero writer then reader; producer three issues ahead
    issue(ins(1, 1, 2, 1, 1, 1, 0, 1));
    issue(ins(1, 0, 0, 1, 1, 1, 8, 0));
    issue(ins(1, 1, 2, 1, 1, 1, 7, 0));
    step(idle);
    step(idle);
    issue(ins(1, 7, 7, 1, 1, 1, 9, 0));
    step(idle);

    // Flush of the consumer in a load-use pair, then a 4-cycle hold with a stalled consumer
    issue(ins(1, 1, 0, 1, 0, 1, 3, 1));
    s = ins(1, 3, 3, 1, 1, 1, 4, 0);
    s.flush = 1'b1;
    step(s);
    issue(ins(1, 2, 0, 1, 0, 1, 9, 1));
    s = ins(1, 9, 9, 1, 1, 1, 10, 0);
    s.hold = 1'b1;
    repeat (4) step(s);
    s.hold = 1'b0;
    issue(s);
    step(idle);

    // Asynchronous reset in the middle of a load-use stall
    issue(ins(1, 1, 0, 1, 0, 1, 5, 1));
    @(negedge clk);
    driveBus(ins(1, 5, 5, 1, 1, 1, 6, 0));
    #1;
    chk("preResetStallA", longint'(busA.stall), 1);
    rst = 1'b1;
    #1;
    checkCleared("midReset");
    @(negedge clk);
    rst = 1'b0;
    driveBus(idle);
    resetModel();
    issue(ins(1, 5, 5, 1, 1, 1, 6, 0));
    step(idle);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      s.hold  = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 7) != 0);
      s.rs    = 5'($urandom_range(0, 7));
      s.rt    = 5'($urandom_range(0, 7));
      s.useRs = 1'($urandom_range(0, 1));
      s.useRt = 1'($urandom_range(0, 1));
      s.wr    = 1'($urandom_range(0, 1));
      s.wa    = 5'($urandom_range(0, 7));
      s.ld    = ($urandom_range(0, 2) == 0);
      step(s);
    end
    step(idle);

    repeat (3) @(posedge clk);
    #2;
    chk("drain", longint'(stallQ.size() + fwdQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
